// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with grant hold: the owner keeps the resource while it requests,
// but is rotated out after MAX_HOLD cycles when others wait, unless lock is held.
`timescale 1ns/1ps
module rr_arbiter_hold #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           lock,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   gnt_nx;
  logic [IDW-1:0] gnt_id_nx, ptr, ptr_nx, win_id;
  logic           preempt_nx, win_found, others, owner_req, timeout;
  logic [7:0]     hold_cnt, hold_nx;

  // Rotating scan from ptr+1; the current owner (its gnt bit) is always excluded.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!win_found && req[IDW'((32'(ptr) + k) % N)] && !gnt[IDW'((32'(ptr) + k) % N)]) begin
        win_found = 1'b1;
        win_id    = IDW'((32'(ptr) + k) % N);
      end
    end
  end

  assign others    = |(req & ~gnt);
  assign owner_req = req[gnt_id];
  assign timeout   = (hold_cnt >= 8'(MAX_HOLD)) && !lock && others;

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    gnt_id_nx  = gnt_id;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    preempt_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nx  = GRANT;
          gnt_nx    = N'(1) << win_id;
          gnt_id_nx = win_id;
          ptr_nx    = win_id;
          hold_nx   = 8'd1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (win_found) begin
            gnt_nx    = N'(1) << win_id;
            gnt_id_nx = win_id;
            ptr_nx    = win_id;
            hold_nx   = 8'd1;
          end else begin
            state_nx  = IDLE;
            gnt_nx    = '0;
            gnt_id_nx = '0;
            hold_nx   = '0;
          end
        end else if (timeout) begin
          gnt_nx     = N'(1) << win_id;
          gnt_id_nx  = win_id;
          ptr_nx     = win_id;
          hold_nx    = 8'd1;
          preempt_nx = 1'b1;
        end else if (hold_cnt < 8'(MAX_HOLD)) begin
          hold_nx = hold_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= IDW'(N - 1);
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      gnt_valid <= |gnt_nx;
      gnt_id    <= gnt_id_nx;
      preempt   <= preempt_nx;
      hold_cnt  <= hold_nx;
      ptr       <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Self-checking bench for rr_arbiter_hold: directed scenarios plus random traffic
// compared cycle by cycle against an owner/hold/pointer reference model.
`timescale 1ns/1ps
module tb_rr_arbiter_hold;
  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 8;

  logic           clk, rst, lock;
  logic [N-1:0]   req, gnt;
  logic           gnt_valid, preempt;
  logic [IDW-1:0] gnt_id;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int m_owner, m_hold, m_ptr;
  bit m_pre;
  logic [N-1:0]   exp_gnt;
  logic [IDW-1:0] exp_id;
  logic           exp_valid, exp_pre;

  rr_arbiter_hold #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick(input int start, input logic [N-1:0] r, input int excl);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_ptr = N - 1; m_pre = 0;
    exp_gnt = '0; exp_id = '0; exp_valid = 0; exp_pre = 0;
  endtask

  task automatic model_update(input logic [N-1:0] r, input logic l);
    int w;
    bit others;
    m_pre = 0;
    if (m_owner < 0) begin
      if (r != 0) begin
        w = pick(m_ptr, r, -1);
        m_owner = w; m_ptr = w; m_hold = 1;
      end
    end else begin
      others = (r & ~(N'(1) << m_owner)) != 0;
      if (!r[m_owner]) begin
        if (others) begin
          w = pick(m_ptr, r, m_owner);
          m_owner = w; m_ptr = w; m_hold = 1;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end else if (m_hold >= MAX_HOLD && !l && others) begin
        w = pick(m_ptr, r, m_owner);
        m_owner = w; m_ptr = w; m_hold = 1; m_pre = 1;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
    exp_gnt   = (m_owner >= 0) ? N'(1) << m_owner : '0;
    exp_id    = (m_owner >= 0) ? IDW'(m_owner) : '0;
    exp_valid = (m_owner >= 0);
    exp_pre   = m_pre;
  endtask

  // Apply inputs, advance one clock edge, update the model, sample #1 later.
  task automatic step(input logic [N-1:0] r, input logic l);
    req = r; lock = l;
    @(posedge clk);
    model_update(r, l);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; lock = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; lock = 1'b0;
    #2;
    vectors++;
    if ({gnt, gnt_valid, gnt_id, preempt} !== '0) begin
      miscompares++;
      $display("FAIL reset: gnt=%b v=%b id=%0d pre=%b, expected all zero", gnt, gnt_valid, gnt_id, preempt);
    end
    do_reset();
  endtask

  task automatic test_first_grant();
    do_reset();
    step(4'b1010, 1'b0);
    vectors++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1 || gnt_valid !== 1'b1 || preempt !== 1'b0) begin
      miscompares++;
      $display("FAIL first_grant: gnt=%b id=%0d v=%b pre=%b, expected 0010 1 1 0", gnt, gnt_id, gnt_valid, preempt);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      logic [IDW-1:0] want_id;
      logic           want_pre;
      step(4'b1111, 1'b0);
      want_id  = IDW'((c / MAX_HOLD) % N);
      want_pre = (c > 0) && (c % MAX_HOLD == 0);
      vectors++;
      if (gnt_id !== want_id || gnt !== (N'(1) << want_id) || preempt !== want_pre || gnt_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rotation c=%0d: gnt=%b id=%0d pre=%b, expected id=%0d pre=%b", c, gnt, gnt_id, preempt, want_id, want_pre);
      end
    end
  endtask

  task automatic test_release_handoff();
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b1100, 1'b0);
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL handoff_hold: gnt=%b, expected 0100", gnt);
    end
    step(4'b1000, 1'b0);
    vectors++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || gnt_valid !== 1'b1 || preempt !== 1'b0) begin
      miscompares++;
      $display("FAIL handoff: gnt=%b id=%0d v=%b pre=%b, expected 1000 3 1 0", gnt, gnt_id, gnt_valid, preempt);
    end
  endtask

  task automatic test_lock();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b0011, 1'b1);
      if (gnt !== 4'b0001 || preempt !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL lock_hold: %0d cycles lost owner 0, expected 0", bad);
    end
    step(4'b0011, 1'b0);
    vectors++;
    if (gnt !== 4'b0010 || preempt !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_release: gnt=%b pre=%b, expected 0010 1", gnt, preempt);
    end
  endtask

  task automatic test_late_newcomer();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step(4'b1000, 1'b0);
      if (gnt !== 4'b1000 || preempt !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL single_owner: %0d bad cycles, expected 0", bad);
    end
    step(4'b1010, 1'b0);
    vectors++;
    if (gnt !== 4'b0010 || preempt !== 1'b1) begin
      miscompares++;
      $display("FAIL newcomer: gnt=%b pre=%b, expected 0010 1", gnt, preempt);
    end
    step(4'b1010, 1'b0);
    vectors++;
    if (gnt !== 4'b0010 || preempt !== 1'b0) begin
      miscompares++;
      $display("FAIL newcomer_pulse: gnt=%b pre=%b, expected 0010 0", gnt, preempt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) step(4'b0110, 1'b0);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({gnt, gnt_valid, gnt_id, preempt} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: gnt=%b v=%b id=%0d pre=%b, expected all zero", gnt, gnt_valid, gnt_id, preempt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    step(4'b1111, 1'b0);
    vectors++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_restart: gnt=%b id=%0d pre=%b, expected 0001 0 0", gnt, gnt_id, preempt);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r, prev;
    logic         l;
    do_reset();
    r = '0; l = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 7) == 0) l = ~l;
      prev = r;
      step(r, l);
      vectors++;
      if ({gnt, gnt_id, gnt_valid, preempt} !== {exp_gnt, exp_id, exp_valid, exp_pre}) begin
        miscompares++;
        $display("FAIL random c=%0d req=%b lock=%b: gnt=%b id=%0d v=%b pre=%b, expected gnt=%b id=%0d v=%b pre=%b",
                 c, prev, l, gnt, gnt_id, gnt_valid, preempt, exp_gnt, exp_id, exp_valid, exp_pre);
      end
      vectors++;
      if (!$onehot0(gnt) || (gnt & ~prev) != '0) begin
        miscompares++;
        $display("FAIL invariant c=%0d: gnt=%b req=%b, expected one-hot subset of req", c, gnt, prev);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_rotation();
    test_release_handoff();
    test_lock();
    test_late_newcomer();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
